mul_ctrl: RTL and testbench
===========================

// Module: mul_ctrl
// PURPOSE
//  Issue/writeback controller for the RV64M multiply path; sits between EXU dispatch and the 64x64 combinational multiplier.
//  Decodes MUL/MULH/MULHSU/MULHU/MULW, registers operands and drives the multiplier with the correct signedness.
//  Waits a fixed settle time, then selects the hi/lo half (sign-extending for MULW) into a held result register.
//  Returns the result to writeback over a valid/ready handshake.
// PARAMETERS
//  MUL_LATENCY  1   cycles spent in CALC before the multiplier output is captured (legal range 1..15)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   request valid
//  in_ready     out  1   controller can accept a request
//  in_op        in   3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101-111 reserved
//  in_src1      in   64  rs1 value
//  in_src2      in   64  rs2 value
//  in_rd        in   5   destination register tag
//  flush        in   1   pipeline kill; abandons any in-flight op
//  mul_src1     out  64  operand A to multiplier
//  mul_src2     out  64  operand B to multiplier
//  mul_signed   out  2   bit0 = src1 signed, bit1 = src2 signed
//  mul_re_hi    in   64  multiplier product [127:64]
//  mul_re_lo    in   64  multiplier product [63:0]
//  out_valid    out  1   result valid
//  out_ready    in   1   writeback accepts result
//  out_result   out  64  rd write data
//  out_rd       out  5   rd tag travelling with result
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=1. out_valid=0, busy=0. out_result/out_rd/mul_src1/mul_src2=0, mul_signed=2'b00. Counter=0.
//  FSM: IDLE -> CALC -> DONE -> IDLE. in_ready=1 only in IDLE; no accept in DONE, even when out_ready=1.
//  IDLE: in_valid & ~flush -> latch op, rd and operands; counter=MUL_LATENCY-1; go CALC.
//  Operand latch, MULW: src1/src2 = sext(src[31:0]) to 64 bits. Other ops: operands latched unchanged.
//  mul_signed per op: MUL 2'b11, MULH 2'b11, MULHSU 2'b01, MULHU 2'b00, MULW 2'b11. Held constant from CALC through DONE.
//  CALC: the counter decrements each cycle.
//   - At counter==0, capture the result and go DONE.
//   - MUL result: mul_re_lo. MULH/MULHSU/MULHU result: mul_re_hi. MULW result: sext(mul_re_lo[31:0]). Reserved op result: 64'd0.
//  Timing: accept in cycle 0 -> out_valid first high in cycle MUL_LATENCY+1.
//  DONE: out_valid=1; out_result and out_rd are stable until the handshake.
//   - out_ready=1 -> IDLE next cycle (out_valid=0).
//  Result correctness: out_result must equal the RV64M architectural value for every op, including MULHSU with negative rs1.
//  flush: in any state, go IDLE next cycle, out_valid=0, result discarded.
//   - flush overrides in_valid in the same cycle (no accept) and overrides out_ready in DONE (no handshake counted).
//  rst mid-operation: same as the reset values above, in the next cycle.
//  Hold rule: in_* changes after accept must not affect the in-flight op.
// CONFIGURATION
//  MUL_ZERO_BYPASS_EN defined:
//   - On accept, if the effective src1==0 or src2==0 (post-MULW sext), skip CALC, go DONE with out_result=0.
//   - out_valid is then high in cycle 1.
//  MUL_ZERO_BYPASS_EN undefined: all ops take the full MUL_LATENCY path; zero operands get no special handling.
// TESTING
//  1. MUL, src1=3, src2=-5, rd=7, MUL_LATENCY=1
//     -> out_valid first high in cycle 2; out_result=0xFFFFFFFFFFFFFFF1, out_rd=7.
//  2. MULHU, src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
//     MULH, src1=src2=-1 -> 0x0.
//     MULHSU, src1=-1, src2=2 -> 0xFFFFFFFFFFFFFFFF.
//  3. MULW, src1=0x000000007FFFFFFF, src2=2 -> 0xFFFFFFFFFFFFFFFE.
//     MULW, src1=0xDEADBEEF00000003, src2=0x1234567800000004 -> 0x000000000000000C.
//  4. out_ready held 0 for 5 cycles in DONE
//     -> out_valid=1 and out_result/out_rd stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle.
//  5. flush in CALC (MUL_LATENCY=4) -> IDLE next cycle, out_valid never asserts.
//     flush with in_valid in IDLE -> nothing accepted.
//     rst in DONE -> all outputs return to reset values.
//  6. MUL_ZERO_BYPASS_EN, MUL src1=0, src2=0x1234 -> out_valid in cycle 1, result 0.
//     Same stimulus without the macro -> out_valid in cycle MUL_LATENCY+1.

Source files
------------

// File: rtl/mul_ctrl.sv
// mul_ctrl: RV64M multiply issue/writeback controller driving an external 64x64 combinational multiplier.
// Optional feature: define MUL_ZERO_BYPASS_EN to finish zero-operand ops without waiting on the multiplier.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake; in_op (MUL/MULH/MULHSU/MULHU/MULW), in_src1/2, in_rd
//   flush                       abandons any in-flight op
//   mul_src1/2, mul_signed      operands and signedness (bit0 src1, bit1 src2) to the multiplier
//   mul_re_hi/lo                multiplier product halves
//   out_valid/out_ready         result handshake; out_result, out_rd
//   busy                        controller not idle
module mul_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [63:0] mul_src1,
  output logic [63:0] mul_src2,
  output logic [1:0]  mul_signed,
  input  logic [63:0] mul_re_hi,
  input  logic [63:0] mul_re_lo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]  op;
  logic [3:0]  cnt;
  logic [63:0] a_eff, b_eff, res;
  logic [1:0]  sgn_in;
  logic        w_in, zero_in, accept;
  always_comb begin
    w_in   = in_op == 3'd4;
    a_eff  = w_in ? {{32{in_src1[31]}}, in_src1[31:0]} : in_src1;
    b_eff  = w_in ? {{32{in_src2[31]}}, in_src2[31:0]} : in_src2;
    sgn_in = in_op == 3'd2 ? 2'b01 : (in_op == 3'd3 || in_op > 3'd4) ? 2'b00 : 2'b11;
    accept = state == IDLE && in_valid && !flush;
`ifdef MUL_ZERO_BYPASS_EN
    zero_in = a_eff == 64'd0 || b_eff == 64'd0;
`else
    zero_in = 1'b0;
`endif
    res = op == 3'd0 ? mul_re_lo
        : (op == 3'd1 || op == 3'd2 || op == 3'd3) ? mul_re_hi
        : op == 3'd4 ? {{32{mul_re_lo[31]}}, mul_re_lo[31:0]} : 64'd0;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = flush ? IDLE
             : state == IDLE ? (in_valid ? (zero_in ? DONE : CALC) : IDLE)
             : state == CALC ? (cnt == 4'd0 ? DONE : CALC)
             : out_ready ? IDLE : DONE;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= 3'd0;
      cnt        <= 4'd0;
      mul_src1   <= 64'd0;
      mul_src2   <= 64'd0;
      mul_signed <= 2'b00;
      out_result <= 64'd0;
      out_rd     <= 5'd0;
    end else if (accept) begin
      op         <= in_op;
      cnt        <= 4'(MUL_LATENCY - 1);
      mul_src1   <= a_eff;
      mul_src2   <= b_eff;
      mul_signed <= sgn_in;
      out_rd     <= in_rd;
      if (zero_in) out_result <= 64'd0;
    end else if (state == CALC) begin
      cnt <= cnt - 4'd1;
      // a flush on the final CALC cycle must not leave a stale capture behind
      if (cnt == 4'd0 && !flush) out_result <= res;
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: randomized and directed checking of mul_ctrl against an architectural RV64M model.
module tb_mul_ctrl;
  localparam int LAT = 3;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0] in_op;
  logic [63:0] in_src1, in_src2, mul_src1, mul_src2, mul_re_hi, mul_re_lo, out_result;
  logic [4:0] in_rd, out_rd;
  logic [1:0] mul_signed;
  logic [127:0] prod;
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit m_active = 1'b0, m_rst = 1'b0, m_init = 1'b0;
  int m_left = 0;
  logic [63:0] m_res, m_a, m_b;
  logic [4:0] m_rd;
  logic [2:0] m_op;
  logic [1:0] m_sgn;

  mul_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .flush(flush),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_signed(mul_signed),
    .mul_re_hi(mul_re_hi), .mul_re_lo(mul_re_lo), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // combinational 64x64 multiplier the controller drives
  assign prod = {{64{mul_signed[0] & mul_src1[63]}}, mul_src1} * {{64{mul_signed[1] & mul_src2[63]}}, mul_src2};
  assign mul_re_hi = prod[127:64];
  assign mul_re_lo = prod[63:0];

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] eff(input logic [2:0] op, input logic [63:0] v);
    return op == 3'd4 ? sx32(v) : v;
  endfunction

  // architectural RV64M result
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    logic [63:0] w;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    w  = {32'd0, a[31:0]} * {32'd0, b[31:0]};
    case (op)
      3'd0: begin p = ua * ub; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: return sx32(w);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_sgn(input logic [2:0] op);
    return op == 3'd2 ? 2'b01 : op == 3'd3 ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return '1;
      2: return {32'd0, $urandom()};
      3: return {32'hFFFF_FFFF, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model: one outstanding op, counted down in cycles until its result is due
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_rst    <= 1'b1;
      m_init   <= 1'b1;
    end else if (!m_init) begin
      m_active <= 1'b0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_rst    <= 1'b0;
        m_op     <= in_op;
        m_rd     <= in_rd;
        m_a      <= eff(in_op, in_src1);
        m_b      <= eff(in_op, in_src2);
        m_sgn    <= ref_sgn(in_op);
        if (BYP && (eff(in_op, in_src1) == 64'd0 || eff(in_op, in_src2) == 64'd0)) begin
          m_left <= 0;
          m_res  <= 64'd0;
        end else begin
          m_left <= LAT;
          m_res  <= ref_mul(in_op, in_src1, in_src2);
        end
      end
    end else if (m_left == 0) begin
      if (out_ready) m_active <= 1'b0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("in_ready", 64'(in_ready), 64'(!m_active));
    chk("busy", 64'(busy), 64'(m_active));
    chk("out_valid", 64'(out_valid), 64'(m_active && m_left == 0));
    if (m_active && m_left == 0) begin
      chk("out_result", out_result, m_res);
      chk("out_rd", 64'(out_rd), 64'(m_rd));
    end
    if (m_active && m_left > 0) begin
      chk("mul_src1", mul_src1, m_a);
      chk("mul_src2", mul_src2, m_b);
      if (m_op <= 3'd4) chk("mul_signed", 64'(mul_signed), 64'(m_sgn));
    end
    if (m_rst) begin
      chk("rst_result", out_result, 64'd0);
      chk("rst_rd", 64'(out_rd), 64'd0);
      chk("rst_src", {mul_src1 | mul_src2}, 64'd0);
      chk("rst_sgn", 64'(mul_signed), 64'd0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rd, input logic [63:0] exp, input int lat,
                      input int hold, input bit ack, input string nm);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom()); in_src1 = rnd64(); in_src2 = rnd64(); in_rd = 5'($urandom());
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_res"}, out_result, exp);
    chk({nm, "_rd"}, 64'(out_rd), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(negedge clk);
      chk({nm, "_hold_flags"}, 64'({out_valid, in_ready, busy}), 64'(3'b101));
      chk({nm, "_hold_res"}, out_result, exp);
      chk({nm, "_hold_rd"}, 64'(out_rd), 64'(rd));
    end
    if (ack) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_ack_idle"}, 64'({busy, out_valid, in_ready}), 64'(3'b001));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
    in_src1 = 64'd0; in_src2 = 64'd0; in_rd = 5'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk("reset_result", out_result, 64'd0);
    send(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1, LAT + 1, 0, 1'b1, "mul");
    send(3'd3, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, LAT + 1, 0, 1'b1, "mulhu");
    send(3'd1, '1, '1, 5'd2, 64'd0, LAT + 1, 0, 1'b1, "mulh");
    send(3'd2, '1, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, LAT + 1, 0, 1'b1, "mulhsu");
    send(3'd4, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, LAT + 1, 0, 1'b1, "mulw_neg");
    send(3'd4, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0004, 5'd5, 64'd12, LAT + 1, 0, 1'b1, "mulw_hi");
    send(3'd3, 64'd6, 64'd7, 5'd9, 64'd0, LAT + 1, 5, 1'b1, "stall");
    send(3'd6, 64'd6, 64'd7, 5'd10, 64'd0, LAT + 1, 0, 1'b1, "reserved");
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd5; in_src2 = 64'd5; in_rd = 5'd11;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("flush_calc", 64'({out_valid, busy}), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", 64'({busy, in_ready}), 64'(2'b01));
    send(3'd0, 64'd9, 64'd9, 5'd12, 64'd81, LAT + 1, 0, 1'b0, "pre_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk("rst_done_result", out_result, 64'd0);
    chk("rst_done_rd", 64'(out_rd), 64'd0);
    send(3'd0, 64'd0, 64'h1234, 5'd13, 64'd0, BYP ? 1 : LAT + 1, 0, 1'b1, "zero");
    repeat (3000) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 19) == 0;
      in_valid = 1'($urandom_range(0, 1));
      in_op = $urandom_range(0, 9) > 7 ? 3'd4 : 3'($urandom_range(0, 7));
      in_src1 = rnd64();
      in_src2 = rnd64();
      in_rd = 5'($urandom());
      out_ready = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
